omsp_spm_cmd_seq: RTL
=====================

# omsp_spm_cmd_seq

Sequencer that serialises SPM protect/unprotect commands into the `omsp_spm_control` update interface. It latches the layout operands, issues the one-cycle `update_spm` pulse, and checks the resulting violation. On a successful protect it then streams the 128-bit module key as eight 16-bit `write_key` words. It sits between the execution-unit command decoder and `omsp_spm_control`, and drives `spm_busy` for the whole operation.

## Interface
- `KEY_TIMEOUT`, default 255: maximum idle cycles allowed between key words before abort; range 1..65535.
- `mclk` input 1: system clock, all state on rising edge.
- `puc_rst_n` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_enable` input 1: 1 = protect (create SPM), 0 = unprotect.
- `cmd_r12`, `cmd_r13`, `cmd_r14`, `cmd_r15` input 16 each: layout operands, sampled at acceptance.
- `spm_r12`, `spm_r13`, `spm_r14`, `spm_r15` output 16 each: latched operands to `omsp_spm_control`; stable from acceptance to response.
- `update_spm` output 1: one-cycle update pulse.
- `enable_spm` output 1: latched `cmd_enable`; valid whenever `update_spm`=1.
- `violation` input 1: from `omsp_spm_control`.
- `key_req` output 1: requesting the next key word.
- `key_valid` input 1: key source presents `key_data`.
- `key_data` input 16: key word.
- `write_key` output 1: equals `key_req & key_valid`.
- `key_in` output 16: equals `key_data`.
- `key_idx` output 3: index of the word being requested, 0..7.
- `spm_busy` output 1: operation in flight.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: result consumed.
- `rsp_err` output 2: 00 = OK, 01 = violation, 10 = key timeout.

## Operation
- States: IDLE, UPDATE, CHECK, KEY, DONE. Reset to IDLE.
- Reset values: all outputs 0. This includes `spm_r*`, `rsp_err`, `key_idx`, and the timeout counter.
- `cmd_ready` is 1 only in IDLE.
- IDLE → UPDATE on acceptance. Acceptance latches `cmd_enable` and `cmd_r12..r15`.
- UPDATE (1 cycle): `update_spm`=1 and `spm_busy`=1. → CHECK.
- CHECK (1 cycle): sample `violation`.
  - `violation`=1: `rsp_err`←01, → DONE.
  - No violation, unprotect: `rsp_err`←00, → DONE.
  - No violation, protect: → KEY, with `key_idx`=0 and the timeout counter cleared.
- KEY: `key_req`=1.
  - Each cycle with `key_valid`=1: `write_key` fires, `key_idx` increments, and the counter clears.
  - Write at `key_idx`=7: `rsp_err`←00, → DONE. `key_idx` wraps to 0.
  - Cycle with `key_valid`=0: the counter increments. When the counter reaches `KEY_TIMEOUT`: `rsp_err`←10, → DONE, and no further writes occur.
  - A timeout and a `key_valid` in the same cycle: the write wins and the counter clears.
  - `violation` is ignored in KEY.
- DONE: `rsp_valid`=1 and `spm_busy`=0. → IDLE on `rsp_ready`. `rsp_err` and `spm_r*` hold until the next acceptance.
- `spm_busy`=1 in UPDATE, CHECK and KEY only.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No partial-key completion occurs.

## Timing
- Acceptance edge at t0: `update_spm` is high during cycle t0+1. `violation` is sampled at the end of t0+2.
- Unprotect, or protect with violation: `rsp_valid` is high from t0+3.
- Protect with the key source always valid: writes occur in t0+3..t0+10, and `rsp_valid` is high from t0+11.
- Minimum command-to-command spacing is 4 cycles. `rsp_ready` held at 1 gives DONE one cycle.
- `write_key` and `key_in` are combinational from `key_valid`/`key_data`, gated by the registered state. There is no key buffering.

## Configuration
- `SPM_KEY_LOAD_EN` defined: behaviour as above.
- Undefined:
  - The KEY state and the timeout counter are removed.
  - CHECK goes directly to DONE with `rsp_err`=00 when there is no violation.
  - `key_req`, `write_key`, `key_in` and `key_idx` are tied to 0.
  - `rsp_err`=10 is never produced.

## Test plan
- Protect with `r12..r15`=0x8000/0x8100/0x0200/0x0300, no violation, key words 0x1111..0x8888 always valid:
  - `update_spm` pulses once at t0+1 with `enable_spm`=1.
  - Eight `write_key` pulses occur with `key_idx` 0..7 and matching `key_in`.
  - `rsp_err`=00 at t0+11.
- Protect with `violation`=1 during CHECK: zero `write_key` pulses, `rsp_err`=01, `rsp_valid` at t0+3.
- Unprotect: one `update_spm` pulse with `enable_spm`=0, no `key_req`, `rsp_err`=00 at t0+3.
- With `KEY_TIMEOUT`=4:
  - Supply 3 words, then hold `key_valid`=0 → `rsp_err`=10 after 4 idle cycles, exactly 3 writes.
  - Word arrives on the 4th idle cycle → write accepted, no timeout.
- Deassert `puc_rst_n` after the 5th key word: all outputs 0 and `cmd_ready`=1 after release. A new command then completes normally.
- Hold `rsp_ready`=0 for 10 cycles with `cmd_valid`=1: `cmd_ready` stays 0 and `spm_r*` stays stable. Acceptance occurs the cycle after `rsp_ready`.

Source files
------------

// File: rtl/omsp_spm_cmd_seq_if.sv
// omsp_spm_cmd_seq_if
// Signal bundle around the SPM command sequencer. It carries the command
// handshake from the execution-unit decoder, the update interface to
// omsp_spm_control, the key-word stream and the response handshake.
// slave  : sequencer side
// master : environment side (decoder, key source, omsp_spm_control)
interface omsp_spm_cmd_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_enable;
   logic [15:0] cmd_r12;
   logic [15:0] cmd_r13;
   logic [15:0] cmd_r14;
   logic [15:0] cmd_r15;
   logic [15:0] spm_r12;
   logic [15:0] spm_r13;
   logic [15:0] spm_r14;
   logic [15:0] spm_r15;
   logic        update_spm;
   logic        enable_spm;
   logic        violation;
   logic        key_req;
   logic        key_valid;
   logic [15:0] key_data;
   logic        write_key;
   logic [15:0] key_in;
   logic [2:0]  key_idx;
   logic        spm_busy;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_err;

   modport slave (
      input  cmd_valid, cmd_enable, cmd_r12, cmd_r13, cmd_r14, cmd_r15,
      input  violation, key_valid, key_data, rsp_ready,
      output cmd_ready, spm_r12, spm_r13, spm_r14, spm_r15,
      output update_spm, enable_spm, key_req, write_key, key_in, key_idx,
      output spm_busy, rsp_valid, rsp_err
   );

   modport master (
      output cmd_valid, cmd_enable, cmd_r12, cmd_r13, cmd_r14, cmd_r15,
      output violation, key_valid, key_data, rsp_ready,
      input  cmd_ready, spm_r12, spm_r13, spm_r14, spm_r15,
      input  update_spm, enable_spm, key_req, write_key, key_in, key_idx,
      input  spm_busy, rsp_valid, rsp_err
   );
endinterface

// File: rtl/omsp_spm_cmd_seq.sv
// omsp_spm_cmd_seq
// Serialises SPM protect/unprotect commands into omsp_spm_control: latches
// the layout operands, pulses update_spm, checks violation and, on a clean
// protect, streams the 128-bit module key as eight 16-bit write_key words.
//
// Build option SPM_KEY_LOAD_EN: when defined, the KEY state and the
// inter-word timeout are present. When undefined, a violation-free command
// completes straight from CHECK with rsp_err=00 and the key outputs are 0.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// UPDATE | one-cycle update_spm pulse, operands presented
// CHECK  | sample violation from omsp_spm_control
// KEY    | key_req high, forward key words, watch idle timeout
// DONE   | rsp_valid high until rsp_ready
module omsp_spm_cmd_seq #(
   parameter int unsigned KEY_TIMEOUT = 255
) (
   input logic               mclk,
   input logic               puc_rst_n,
   omsp_spm_cmd_seq_if.slave bus
);

   if ((KEY_TIMEOUT < 1) || (KEY_TIMEOUT > 65535)) begin : g_bad_timeout
      $error("KEY_TIMEOUT must be in 1..65535");
   end

`ifdef SPM_KEY_LOAD_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0, UPDATE = 3'd1, CHECK = 3'd2, KEY = 3'd3, DONE = 3'd4
   } state_t;
   // Idle count at which the next idle cycle would exceed the budget.
   localparam logic [15:0] TO_LAST = 16'(KEY_TIMEOUT - 1);
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, UPDATE = 3'd1, CHECK = 3'd2, DONE = 3'd4
   } state_t;
`endif

   state_t      state;
   logic        cmd_ready_q;
   logic        update_spm_q;
   logic        enable_spm_q;
   logic        spm_busy_q;
   logic        rsp_valid_q;
   logic [1:0]  rsp_err_q;
   logic [15:0] spm_r12_q;
   logic [15:0] spm_r13_q;
   logic [15:0] spm_r14_q;
   logic [15:0] spm_r15_q;
`ifdef SPM_KEY_LOAD_EN
   logic        key_req_q;
   logic [2:0]  key_idx_q;
   logic [15:0] to_cnt_q;
`endif

   // Command sequencer: state transitions and all registered outputs.
   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state        <= IDLE;
         cmd_ready_q  <= 1'b0;
         update_spm_q <= 1'b0;
         enable_spm_q <= 1'b0;
         spm_busy_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 2'b00;
         spm_r12_q    <= '0;
         spm_r13_q    <= '0;
         spm_r14_q    <= '0;
         spm_r15_q    <= '0;
`ifdef SPM_KEY_LOAD_EN
         key_req_q    <= 1'b0;
         key_idx_q    <= '0;
         to_cnt_q     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // cmd_ready is held low through reset and rises on the
               // first clock afterwards, so all outputs start at 0.
               cmd_ready_q <= 1'b1;
               if (bus.cmd_valid && cmd_ready_q) begin
                  cmd_ready_q  <= 1'b0;
                  enable_spm_q <= bus.cmd_enable;
                  spm_r12_q    <= bus.cmd_r12;
                  spm_r13_q    <= bus.cmd_r13;
                  spm_r14_q    <= bus.cmd_r14;
                  spm_r15_q    <= bus.cmd_r15;
                  update_spm_q <= 1'b1;
                  spm_busy_q   <= 1'b1;
                  state        <= UPDATE;
               end
            end
            UPDATE: begin
               update_spm_q <= 1'b0;
               state        <= CHECK;
            end
            CHECK: begin
               if (bus.violation) begin
                  rsp_err_q   <= 2'b01;
                  spm_busy_q  <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= DONE;
               end
`ifdef SPM_KEY_LOAD_EN
               else if (enable_spm_q) begin
                  key_req_q <= 1'b1;
                  key_idx_q <= '0;
                  to_cnt_q  <= '0;
                  state     <= KEY;
               end
`endif
               else begin
                  rsp_err_q   <= 2'b00;
                  spm_busy_q  <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
`ifdef SPM_KEY_LOAD_EN
            KEY: begin
               // A word arriving on the would-be timeout cycle still wins.
               if (bus.key_valid) begin
                  key_idx_q <= key_idx_q + 3'd1;
                  to_cnt_q  <= '0;
                  if (key_idx_q == 3'd7) begin
                     rsp_err_q   <= 2'b00;
                     key_req_q   <= 1'b0;
                     spm_busy_q  <= 1'b0;
                     rsp_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end else if (to_cnt_q == TO_LAST) begin
                  rsp_err_q   <= 2'b10;
                  key_req_q   <= 1'b0;
                  spm_busy_q  <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  to_cnt_q <= to_cnt_q + 16'd1;
               end
            end
`endif
            DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.update_spm = update_spm_q;
   assign bus.enable_spm = enable_spm_q;
   assign bus.spm_busy   = spm_busy_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.spm_r12    = spm_r12_q;
   assign bus.spm_r13    = spm_r13_q;
   assign bus.spm_r14    = spm_r14_q;
   assign bus.spm_r15    = spm_r15_q;

`ifdef SPM_KEY_LOAD_EN
   // Key words pass straight through; there is no buffering.
   assign bus.key_req   = key_req_q;
   assign bus.write_key = key_req_q & bus.key_valid;
   assign bus.key_in    = key_req_q ? bus.key_data : 16'h0000;
   assign bus.key_idx   = key_idx_q;
`else
   assign bus.key_req   = 1'b0;
   assign bus.write_key = 1'b0;
   assign bus.key_in    = 16'h0000;
   assign bus.key_idx   = 3'd0;
`endif

endmodule
